// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared raster timing defaults for vga_timing_gen.
// Default timing is 1280x1024 @ 60 Hz. Coordinates are 12 bits wide,
// so every axis total must fit in 4096 counts.
package vga_timing_pkg;

    // Coordinate bus width shared by both axes
    localparam int COORD_W = 12;

    typedef logic [COORD_W-1:0] coord_t;

    // Horizontal defaults (pixels)
    localparam int DEF_H_ACTIVE = 1280;
    localparam int DEF_H_FP     = 48;
    localparam int DEF_H_SYNC   = 112;
    localparam int DEF_H_BP     = 248;

    // Vertical defaults (lines)
    localparam int DEF_V_ACTIVE = 1024;
    localparam int DEF_V_FP     = 1;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BP     = 38;

    // Default sync polarities: high-active pulses
    localparam bit DEF_HS_POL = 1'b1;
    localparam bit DEF_VS_POL = 1'b1;

    // Counts per axis: visible region plus both porches and the sync pulse
    function automatic int axisTotal(input int active, input int fp,
                                     input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis. A wrapping counter that starts at its
// last count out of reset, so the first enabled step lands on 0. The sync and
// active flags are decoded from the next count and registered on the same
// edge as the count, which keeps them aligned with the coordinate they tag.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter bit POL    = 1'b1
) (
    input  logic   CLK,
    input  logic   RESET,
    input  logic   countEn,
    output coord_t count,
    output logic   atLast,
    output logic   syncLvl,
    output logic   isActive
);

    localparam int     TOTAL      = axisTotal(ACTIVE, FP, SYNC, BP);
    localparam coord_t LAST       = coord_t'(TOTAL - 1);
    localparam coord_t ACT_LIMIT  = coord_t'(ACTIVE);
    localparam coord_t SYNC_START = coord_t'(ACTIVE + FP);
    localparam coord_t SYNC_END   = coord_t'(ACTIVE + FP + SYNC - 1);

    coord_t countNext;
    logic   inSyncNext;
    logic   inActiveNext;

    // Terminal count is taken from the current value; it gates the other axis
    assign atLast = (count == LAST);

    // Next count and window decodes of that next count
    always_comb begin
        countNext    = atLast ? '0 : count + 1'b1;
        inSyncNext   = (countNext >= SYNC_START) && (countNext <= SYNC_END);
        inActiveNext = (countNext < ACT_LIMIT);
    end

    // Count and flags update together, only on enabled edges
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count    <= LAST;
            syncLvl  <= ~POL;
            isActive <= 1'b0;
        end else if (countEn) begin
            count    <= countNext;
            syncLvl  <= inSyncNext ? POL : ~POL;
            isActive <= inActiveNext;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running VGA raster generator. Emits registered pixel
// coordinates, sync pulses, active-video and frame-start flags, all updated on
// the same PIX_EN edge. Optional frame counter is built when the macro
// VGA_FRAME_CNT_EN is defined; otherwise the VGA_frameCount port is absent.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = DEF_HS_POL,
    parameter bit VS_POL   = DEF_VS_POL
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               PIX_EN,
    output logic [COORD_W-1:0] VGA_horzCoord,
    output logic [COORD_W-1:0] VGA_vertCoord,
    output logic               VGA_HS,
    output logic               VGA_VS,
    output logic               VGA_active,
`ifdef VGA_FRAME_CNT_EN
    output logic [15:0]        VGA_frameCount,
`endif
    output logic               VGA_frameStart
);

    logic hAtLast;
    logic vAtLast;
    logic hActive;
    logic vActive;
    logic vStep;
    logic frameWrap;
    logic frameStartReg;

    // Vertical axis steps only on the edge where the line wraps
    assign vStep     = PIX_EN & hAtLast;
    // Edge that moves the raster from the last pixel onto (0,0)
    assign frameWrap = PIX_EN & hAtLast & vAtLast;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (HS_POL)
    ) hAxis (
        .CLK      (CLK),
        .RESET    (RESET),
        .countEn  (PIX_EN),
        .count    (VGA_horzCoord),
        .atLast   (hAtLast),
        .syncLvl  (VGA_HS),
        .isActive (hActive)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (VS_POL)
    ) vAxis (
        .CLK      (CLK),
        .RESET    (RESET),
        .countEn  (vStep),
        .count    (VGA_vertCoord),
        .atLast   (vAtLast),
        .syncLvl  (VGA_VS),
        .isActive (vActive)
    );

    // Both window flags are registers that change with the coordinates
    assign VGA_active = hActive & vActive;

    // Frame-start flag is high for exactly the (0,0) pixel
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            frameStartReg <= 1'b0;
        end else if (PIX_EN) begin
            frameStartReg <= hAtLast & vAtLast;
        end
    end

    assign VGA_frameStart = frameStartReg;

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frameCountReg;

    // Counts entries into (0,0); the first one after reset makes it read 1
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            frameCountReg <= '0;
        end else if (frameWrap) begin
            frameCountReg <= frameCountReg + 16'd1;
        end
    end

    assign VGA_frameCount = frameCountReg;
`else
    // Without the counter the wrap strobe has no consumer
    logic unusedWrap;
    assign unusedWrap = frameWrap;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: drives two generators (a compact timing for full-frame
// coverage and the default 1280x1024 timing for line-level checks) from one
// PIX_EN/RESET stimulus. Expected outputs come from a raster model indexed by
// the number of enabled pixel edges since reset.
module tb_vga_timing_gen;

    // Compact timing: 28 x 14 raster, low-active HS
    localparam int S_HA = 16, S_HF = 3, S_HS = 4, S_HB = 5;
    localparam int S_VA = 8,  S_VF = 1, S_VS = 3, S_VB = 2;
    localparam bit S_HP = 1'b0, S_VP = 1'b1;

    typedef struct {
        int h;
        int v;
        bit hs;
        bit vs;
        bit act;
        bit fs;
        int fc;
    } exp_t;

    typedef struct {
        exp_t s;
        exp_t d;
    } pair_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic pixEn = 1'b0;

    logic [11:0] sH, sV, dH, dV;
    logic sHs, sVs, sAct, sFs, dHs, dVs, dAct, dFs;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] sFc, dFc;
`endif

    int nChecks = 0;
    int nFails  = 0;
    longint n = 0;
    pair_t sb[$];

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE (S_HA), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
        .V_ACTIVE (S_VA), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB),
        .HS_POL   (S_HP), .VS_POL (S_VP)
    ) dutSmall (
        .CLK            (clk),
        .RESET          (rst),
        .PIX_EN         (pixEn),
        .VGA_horzCoord  (sH),
        .VGA_vertCoord  (sV),
        .VGA_HS         (sHs),
        .VGA_VS         (sVs),
        .VGA_active     (sAct),
`ifdef VGA_FRAME_CNT_EN
        .VGA_frameCount (sFc),
`endif
        .VGA_frameStart (sFs)
    );

    vga_timing_gen dutDflt (
        .CLK            (clk),
        .RESET          (rst),
        .PIX_EN         (pixEn),
        .VGA_horzCoord  (dH),
        .VGA_vertCoord  (dV),
        .VGA_HS         (dHs),
        .VGA_VS         (dVs),
        .VGA_active     (dAct),
`ifdef VGA_FRAME_CNT_EN
        .VGA_frameCount (dFc),
`endif
        .VGA_frameStart (dFs)
    );

    // Raster model: state after k enabled edges since reset
    function automatic exp_t model(longint k, int ha, int hf, int hsw, int hb,
                                   int va, int vf, int vsw, int vb,
                                   bit hp, bit vp);
        exp_t   e;
        int     ht = ha + hf + hsw + hb;
        int     vt = va + vf + vsw + vb;
        longint frame = longint'(ht) * longint'(vt);
        longint pos;
        if (k == 0) begin
            e.h = ht - 1; e.v = vt - 1;
            e.hs = !hp; e.vs = !vp;
            e.act = 1'b0; e.fs = 1'b0; e.fc = 0;
        end else begin
            pos   = (k - 1) % frame;
            e.h   = int'(pos % ht);
            e.v   = int'(pos / ht);
            e.hs  = (e.h >= ha + hf && e.h < ha + hf + hsw) ? hp : !hp;
            e.vs  = (e.v >= va + vf && e.v < va + vf + vsw) ? vp : !vp;
            e.act = (e.h < ha) && (e.v < va);
            e.fs  = (pos == 0);
            e.fc  = int'(((k - 1) / frame + 1) % 65536);
        end
        return e;
    endfunction

    function automatic pair_t expectPair(longint k);
        pair_t p;
        p.s = model(k, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, S_HP, S_VP);
        p.d = model(k, 1280, 48, 112, 248, 1024, 1, 3, 38, 1'b1, 1'b1);
        return p;
    endfunction

    task automatic chk(input string name, input int got, input int want);
        nChecks++;
        if (got != want) begin
            nFails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic cmpSmall(input string tag, input exp_t e);
        chk({tag, " small.h"},  int'(sH),  e.h);
        chk({tag, " small.v"},  int'(sV),  e.v);
        chk({tag, " small.hs"}, int'(sHs), int'(e.hs));
        chk({tag, " small.vs"}, int'(sVs), int'(e.vs));
        chk({tag, " small.act"}, int'(sAct), int'(e.act));
        chk({tag, " small.fs"}, int'(sFs), int'(e.fs));
`ifdef VGA_FRAME_CNT_EN
        chk({tag, " small.fc"}, int'(sFc), e.fc);
`endif
    endtask

    task automatic cmpDflt(input string tag, input exp_t e);
        chk({tag, " dflt.h"},  int'(dH),  e.h);
        chk({tag, " dflt.v"},  int'(dV),  e.v);
        chk({tag, " dflt.hs"}, int'(dHs), int'(e.hs));
        chk({tag, " dflt.vs"}, int'(dVs), int'(e.vs));
        chk({tag, " dflt.act"}, int'(dAct), int'(e.act));
        chk({tag, " dflt.fs"}, int'(dFs), int'(e.fs));
`ifdef VGA_FRAME_CNT_EN
        chk({tag, " dflt.fc"}, int'(dFc), e.fc);
`endif
    endtask

    // Monitor: one expected entry is consumed after every active edge
    initial begin
        pair_t p;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                p = sb.pop_front();
                cmpSmall("edge", p.s);
                cmpDflt("edge", p.d);
                $display("txn small=(%0d,%0d) dflt=(%0d,%0d) en=%0b rst=%0b",
                         sH, sV, dH, dV, pixEn, rst);
            end
        end
    end

    // One clock of stimulus: inputs set on the falling edge, expectation queued
    task automatic step(input bit en, input bit r);
        @(negedge clk);
        rst   = r;
        pixEn = en;
        if (r) n = 0;
        else if (en) n++;
        sb.push_back(expectPair(n));
    endtask

    // Reset raised between edges must clear outputs without waiting for a clock
    task automatic asyncReset();
        pair_t p;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n = 0;
        p = expectPair(0);
        cmpSmall("async", p.s);
        cmpDflt("async", p.d);
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (3) step(1'b0, 1'b1);
        // Release, idle, then a single pixel pulse onto (0,0)
        repeat (2) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        // Continuous run: several compact frames, one full default line
        repeat (1800) step(1'b1, 1'b0);
        // One-in-three enable
        for (int i = 0; i < 300; i++) step(i % 3 == 0, 1'b0);
        // Random enable with a mid-frame asynchronous reset
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                asyncReset();
                repeat (2) step(1'b1, 1'b1);
            end
            step(1'($urandom_range(0, 1)), 1'b0);
        end
        // Continuous run after the reset to cross frame boundaries again
        repeat (900) step(1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
